// File: rtl/mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : mult_shift_add (with helpers mux_2_1, shift_left_1)
// Purpose  : Iterative signed WIDTH x WIDTH shift-and-add multiplier for the
//            ALU multiply path. One multiplier bit is retired per clock.
//            The operand magnitudes are multiplied unsigned. The sign is
//            applied at the end. The low WIDTH bits are returned together
//            with a signed-overflow flag.
// Ports    : clock          - rising-edge clock
//            reset          - asynchronous active-low reset
//            ctrl_mult      - start strobe; operands are captured on that edge
//            data_operandA  - multiplicand, two's complement
//            data_operandB  - multiplier, two's complement
//            data_result    - low WIDTH bits of the signed product
//            data_exception - product not representable in WIDTH bits
//            data_resultRDY - one-cycle result-valid pulse
//            busy           - high while iterating
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// mux_2_1 : single-bit 2:1 multiplexer (sel=1 selects d1)
// ----------------------------------------------------------------------------
module mux_2_1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

// ----------------------------------------------------------------------------
// shift_left_1 : one-bit logical left shift built from 2:1 muxes.
//   en=1 -> dout = {din[WIDTH-2:0], 1'b0}; en=0 -> dout = din
// ----------------------------------------------------------------------------
module shift_left_1 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
        // Zero fill into bit 0
        mux_2_1 u_mux (
          .d0  (din[0]),
          .d1  (1'b0),
          .sel (en),
          .y   (dout[0])
        );
      end else begin : g_upper
        mux_2_1 u_mux (
          .d0  (din[i]),
          .d1  (din[i-1]),
          .sel (en),
          .y   (dout[i])
        );
      end
    end
  endgenerate
endmodule

// ----------------------------------------------------------------------------
// mult_shift_add : top level
// ----------------------------------------------------------------------------
module mult_shift_add #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter value during the final iteration
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         state;
  logic [CNT_W-1:0]   counter;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               neg;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand_shifted;
  logic [WIDTH:0]     prod_top;
  logic               exc_next;
  logic               last_iter;
  logic               shift_en;

  // Magnitudes. The most negative value negates to itself. Read as unsigned,
  // that result is the correct magnitude.
  always_comb begin
    abs_a = data_operandA;
    abs_b = data_operandB;
    if (data_operandA[WIDTH-1]) abs_a = -data_operandA;
    if (data_operandB[WIDTH-1]) abs_b = -data_operandB;
  end

  // The accumulator value after the current iteration. The finishing edge
  // must see the final add, so the sign is applied to acc_next, not to acc.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  always_comb begin
    prod = acc_next;
    if (neg) prod = -acc_next;
  end

  // The product fits in WIDTH signed bits only when bits [2W-1:W-1] are all
  // copies of the sign bit.
  assign prod_top  = prod[2*WIDTH-1:WIDTH-1];
  assign exc_next  = ~((&prod_top) | ~(|prod_top));
  assign last_iter = (counter == LAST_ITER);
  assign shift_en  = (state == RUN);

  shift_left_1 #(
    .WIDTH (2*WIDTH)
  ) u_shl (
    .din  (mcand),
    .en   (shift_en),
    .dout (mcand_shifted)
  );

  // --------------------------------------------------------------------------
  // Sequential control and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      counter        <= '0;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      neg            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_mult) begin
        // A start takes priority in every state. During RUN it aborts the
        // operation in flight, even on the edge that would have finished it.
        state   <= RUN;
        counter <= '0;
        mcand   <= {{WIDTH{1'b0}}, abs_a};
        mplier  <= abs_b;
        acc     <= '0;
        neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        busy    <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            acc     <= acc_next;
            mcand   <= mcand_shifted;
            mplier  <= mplier >> 1;
            counter <= counter + 1'b1;
            if (last_iter) begin
              state          <= DONE;
              data_result    <= prod[WIDTH-1:0];
              data_exception <= exc_next;
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
            end
          end
          DONE:    state <= IDLE;
          IDLE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_shift_add
// Purpose  : Self-checking bench for mult_shift_add. It covers directed
//            corners and randomized operands against a 64-bit arithmetic
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mult_shift_add;

  localparam int WIDTH = 32;

  logic             clock;
  logic             reset;
  logic             ctrl_mult;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  mult_shift_add #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: the full signed product in 64-bit arithmetic
  task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e);
    longint p;
    logic [63:0] pv;
    p  = longint'($signed(a)) * longint'($signed(b));
    pv = p;
    r  = pv[31:0];
    e  = (p != longint'($signed(pv[31:0])));
  endtask

  // Drive a start strobe now, then return 1ns after the edge that samples it
  task automatic start_now(input logic [31:0] a, input logic [31:0] b);
    ctrl_mult     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_mult     = 1'b0;
    data_operandA = $urandom;  // operands need not stay stable
    data_operandB = $urandom;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start_now(a, b);
  endtask

  // Wait a bounded number of edges for the pulse, then check the latency and the
  // result. Returns 1ns after the pulse edge, which is inside the DONE cycle.
  task automatic expect_result(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] r;
    logic        e;
    int          lat;
    ref_mul(a, b, r, e);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'd32);
    check({tag, "_result"}, {32'd0, data_result}, {32'd0, r});
    check({tag, "_exc"}, {63'd0, data_exception}, {63'd0, e});
    check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic expect_pulse_end(input string tag);
    @(posedge clock);
    #1;
    check({tag, "_rdy_drop"}, {63'd0, data_resultRDY}, 64'd0);
  endtask

  logic [31:0] corners[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                              32'h0000_0000, 32'h0000_0001, 32'h0001_0000};

  initial begin
    logic [31:0] ra, rb;
    int pulses;
    reset         = 1'b0;
    ctrl_mult     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", {32'd0, data_result}, 64'd0);
    check("reset_exc", {63'd0, data_exception}, 64'd0);
    check("reset_rdy", {63'd0, data_resultRDY}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Basic operations
    start(32'd3, 32'd5);
    expect_result(32'd3, 32'd5, "3x5");
    check("3x5_value", {32'd0, data_result}, 64'd15);
    expect_pulse_end("3x5");

    start(32'hFFFF_FFF9, 32'd6);
    expect_result(32'hFFFF_FFF9, 32'd6, "m7x6");
    check("m7x6_value", {32'd0, data_result}, 64'hFFFF_FFD6);
    expect_pulse_end("m7x6");

    start(32'd0, 32'hFFFF_FFFF);
    expect_result(32'd0, 32'hFFFF_FFFF, "0xm1");
    expect_pulse_end("0xm1");

    // Overflow boundaries
    start(32'h7FFF_FFFF, 32'd2);
    expect_result(32'h7FFF_FFFF, 32'd2, "max_x2");
    check("max_x2_exc_set", {63'd0, data_exception}, 64'd1);
    expect_pulse_end("max_x2");

    start(32'h8000_0000, 32'hFFFF_FFFF);
    expect_result(32'h8000_0000, 32'hFFFF_FFFF, "min_xm1");
    check("min_xm1_exc_set", {63'd0, data_exception}, 64'd1);

    start(32'h8000_0000, 32'd1);
    expect_result(32'h8000_0000, 32'd1, "min_x1");
    check("min_x1_exc_clear", {63'd0, data_exception}, 64'd0);

    start(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    expect_result(32'h7FFF_FFFF, 32'h7FFF_FFFF, "max_xmax");

    // Abort mid-run. Only the restarted operation may produce a pulse.
    start(32'd10, 32'd10);
    repeat (11) @(posedge clock);
    start(32'd4, 32'd4);
    expect_result(32'd4, 32'd4, "abort");
    check("abort_value", {32'd0, data_result}, 64'd16);
    expect_pulse_end("abort");

    // Asynchronous reset mid-run
    start(32'd9, 32'd9);
    repeat (19) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("areset_result", {32'd0, data_result}, 64'd0);
    check("areset_exc", {63'd0, data_exception}, 64'd0);
    check("areset_rdy", {63'd0, data_resultRDY}, 64'd0);
    check("areset_busy", {63'd0, busy}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    check("areset_no_pulse", 64'(pulses), 64'd0);
    start(32'd2, 32'd3);
    expect_result(32'd2, 32'd3, "post_reset");
    check("post_reset_value", {32'd0, data_result}, 64'd6);
    expect_pulse_end("post_reset");

    // Back-to-back: a new start is issued in the DONE cycle
    start(32'd2, 32'd2);
    expect_result(32'd2, 32'd2, "b2b_first");
    check("b2b_first_value", {32'd0, data_result}, 64'd4);
    start_now(32'd1, 32'd7);
    check("b2b_pulse_single", {63'd0, data_resultRDY}, 64'd0);
    check("b2b_hold_result", {32'd0, data_result}, 64'd4);
    expect_result(32'd1, 32'd7, "b2b_second");
    check("b2b_second_value", {32'd0, data_result}, 64'd7);
    expect_pulse_end("b2b_second");

    // Randomized operands, some drawn from the corner values
    for (int n = 0; n < 24; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >>> $urandom_range(8, 28);
      start(ra, rb);
      expect_result(ra, rb, "rand");
      expect_pulse_end("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_shift_add.md
Name: mult_shift_add

Overview:
- Iterative signed 32x32 multiplier for the ALU's multiply path.
- It consumes the one-bit left-shift stage (mux_2_1 based, zero-fill) once per cycle to advance the multiplicand.
- One multiplier bit is retired per clock, and the low 32 bits of the product are returned with an overflow flag.
- It sits between the decode/ALU control (ctrl_mult) and the writeback mux (data_result, data_resultRDY).

Parameters:
- WIDTH, 32: operand and result width.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- ctrl_mult  input  1  start strobe, sampled on the rising edge. Operands are captured on that edge.
- data_operandA  input  WIDTH  multiplicand, two's complement.
- data_operandB  input  WIDTH  multiplier, two's complement.
- data_result  output  WIDTH  low WIDTH bits of the signed product.
- data_exception  output  1  set when the signed product is not representable in WIDTH bits.
- data_resultRDY  output  1  one-cycle pulse marking the result valid.
- busy  output  1  high while iterating.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; counter=0; accumulator and shift registers cleared.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Deassertion is synchronised by the user; the block acts from the first rising edge with reset=1.
- States: IDLE, RUN, DONE.
  - IDLE --ctrl_mult--> RUN.
  - RUN --(counter==WIDTH-1)--> DONE.
  - DONE --(next edge)--> IDLE, or DONE --ctrl_mult--> RUN.
- Start (any state, ctrl_mult=1 on an edge):
  - mcand(2*WIDTH) = {0, |A|}; mplier(WIDTH) = |B|; acc(2*WIDTH) = 0.
  - neg = A[WIDTH-1] ^ B[WIDTH-1]; counter = 0; state = RUN.
  - |x| is the two's-complement negate when the MSB is set. |0x80000000| = 0x80000000 as unsigned, which is valid.
- RUN, each edge:
  - If mplier[0], then acc += mcand (2*WIDTH unsigned add, no carry out possible).
  - mcand is shifted left 1 through the left-shift stage, with zero into bit 0.
  - mplier is shifted right 1 logically; counter += 1.
  - Exactly WIDTH iterations run. There is no early exit on mplier==0, so latency is fixed.
- Finish (edge that leaves RUN):
  - prod = neg ? -acc : acc, over 2*WIDTH bits. neg with acc==0 gives 0.
  - data_result <= prod[WIDTH-1:0].
  - data_exception <= (prod[2*WIDTH-1:WIDTH-1] not all equal).
  - data_resultRDY <= 1 for exactly one cycle; busy <= 0.
- Latency:
  - Start sampled at edge E0.
  - data_resultRDY is high in the cycle after edge E0+WIDTH (32 edges later) and low after E0+WIDTH+1.
  - busy is high from after E0 until after E0+WIDTH.
- Hold rules:
  - data_result and data_exception hold their last values until the next finish.
  - Operands are not required to be stable after the start edge.
- ctrl_mult during RUN: abort and restart with the newly sampled operands. No data_resultRDY is produced for the aborted operation, and the counter restarts at 0.
- ctrl_mult in DONE: the new operation starts and the pulse still completes that cycle.
- Reset mid-RUN: immediate return to the reset values. No pulse is produced.
- Overflow boundaries:
  - 0x80000000 * 1 → 0x80000000, exc 0.
  - 0x80000000 * 0xFFFFFFFF → 0x80000000, exc 1.
  - 0x7FFFFFFF * 0x7FFFFFFF → exc 1.

Test Plan:
- Reset low 3 cycles, then A=3, B=5, ctrl_mult pulse → after 32 edges data_resultRDY pulses 1 cycle, data_result=15, exc=0, busy low after.
- A=0xFFFFFFF9 (-7), B=6 → data_result=0xFFFFFFD6 (-42), exc=0. Then A=0, B=0xFFFFFFFF → 0, exc=0.
- A=0x7FFFFFFF, B=2 → data_result=0xFFFFFFFE, exc=1. A=0x80000000, B=0xFFFFFFFF → 0x80000000, exc=1. A=0x80000000, B=1 → 0x80000000, exc=0.
- Start A=10, B=10; at iteration 12 pulse ctrl_mult with A=4, B=4 → exactly one data_resultRDY, 32 edges after the second start, data_result=16.
- Start A=9, B=9; drive reset low at iteration 20 → all outputs 0 asynchronously, no pulse. After release, A=2, B=3 → 6.
- Back-to-back: pulse ctrl_mult (A=1, B=7) in the DONE cycle of a prior op (A=2, B=2) → pulse with 4, then 32 edges later pulse with 7.
